// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared op encodings, FSM states and sign helpers for the mul/div unit
package muldiv_pkg;

    localparam int ITERATIONS = 32;

    // CALC leaves once the counter holds this value and is bumped one more time.
    localparam logic [5:0] CNT_LAST = 6'(ITERATIONS - 1);

    // funct3 encodings of the RV32M group
    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    function automatic logic [31:0] neg32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

    function automatic logic [63:0] neg64(input logic [63:0] v);
        return ~v + 64'd1;
    endfunction

    // Magnitude of v when it is interpreted as signed, else v untouched.
    // 0x80000000 maps to itself, which is the correct unsigned magnitude.
    function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? neg32(v) : v;
    endfunction

    function automatic logic rs1_is_signed(input logic [2:0] f3);
        return (f3 == OP_MULH) || (f3 == OP_MULHSU) || (f3 == OP_DIV) || (f3 == OP_REM);
    endfunction

    function automatic logic rs2_is_signed(input logic [2:0] f3);
        return (f3 == OP_MULH) || (f3 == OP_DIV) || (f3 == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// rtl/muldiv_if.sv - request/response bundle between execute stage and mul/div unit
// start_i, funct3_i, rs1_i, rs2_i : request side, driven by the master
// busy_o, done_o, result_o        : response side, driven by the slave (the unit)
interface muldiv_if #(
    parameter int XLEN = 32
);
    logic            start_i;
    logic [2:0]      funct3_i;
    logic [XLEN-1:0] rs1_i;
    logic [XLEN-1:0] rs2_i;
    logic            busy_o;
    logic            done_o;
    logic [XLEN-1:0] result_o;

    modport master (
        output start_i, funct3_i, rs1_i, rs2_i,
        input  busy_o, done_o, result_o
    );

    modport slave (
        input  start_i, funct3_i, rs1_i, rs2_i,
        output busy_o, done_o, result_o
    );
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit with fixed 34-cycle latency
// clk_i  : clock, rising edge
// rst_i  : asynchronous active-high reset
// bus    : muldiv_if.slave - start/funct3/rs1/rs2 in, busy/done/result out
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic     clk_i,
    input  logic     rst_i,
    muldiv_if.slave  bus
);

    state_e            state_q, state_d;
    logic [5:0]        cnt_q;
    logic [2:0]        f3_q;
    logic              sign_a_q;
    logic              sign_b_q;
    // Multiply: multiplicand magnitude. Divide: divisor magnitude.
    logic [XLEN-1:0]   opnd_q;
    // Multiply: {partial product high, multiplier shifting out}.
    // Divide:   {partial remainder, dividend shifting out / quotient shifting in}.
    logic [2*XLEN-1:0] acc_q;
    logic [XLEN-1:0]   result_q;

    logic              accept;
    logic              is_div;
    logic [XLEN-1:0]   abs_a;
    logic [XLEN-1:0]   abs_b;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     rem_shift;
    logic [XLEN:0]     div_diff;
    logic [2*XLEN-1:0] acc_step;
    logic [2*XLEN-1:0] prod_fixed;
    logic [XLEN-1:0]   quo_fixed;
    logic [XLEN-1:0]   rem_fixed;
    logic [XLEN-1:0]   fix_result;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (bus.start_i) state_d = ST_CALC;
            ST_CALC: if (cnt_q == CNT_LAST) state_d = ST_FIX;
            ST_FIX:  state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign accept = (state_q == ST_IDLE) && bus.start_i;

    // ------------------------------------------------------------------
    // Operand conditioning at latch time
    // ------------------------------------------------------------------
    assign abs_a = abs32(bus.rs1_i, rs1_is_signed(bus.funct3_i));
    assign abs_b = abs32(bus.rs2_i, rs2_is_signed(bus.funct3_i));

    // ------------------------------------------------------------------
    // One iteration of either algorithm
    // ------------------------------------------------------------------
    assign is_div = f3_q[2];

    // Shift-add: add the multiplicand into the high half when the current
    // multiplier LSB is set, then shift the 65-bit {carry, acc} right.
    assign mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);

    // Restoring divide: bring the next dividend bit into the remainder and
    // try the subtraction. Because remainder < divisor before the shift,
    // 33 bits are enough for the sign of the trial to be exact.
    assign rem_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    assign div_diff  = rem_shift - {1'b0, opnd_q};

    always_comb begin
        acc_step = {mul_sum, acc_q[XLEN-1:1]};
        if (is_div) begin
            if (div_diff[XLEN]) begin
                acc_step = {rem_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
            end else begin
                acc_step = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
            end
        end
    end

    // ------------------------------------------------------------------
    // Sign fix-up and result selection
    // ------------------------------------------------------------------
    assign prod_fixed = (sign_a_q ^ sign_b_q) ? neg64(acc_q) : acc_q;
    // A zero divisor yields an all-ones quotient that must stay all-ones
    // regardless of the dividend sign, so the negate is suppressed there.
    assign quo_fixed  = ((sign_a_q ^ sign_b_q) && (opnd_q != '0))
                        ? neg32(acc_q[XLEN-1:0]) : acc_q[XLEN-1:0];
    assign rem_fixed  = sign_a_q ? neg32(acc_q[2*XLEN-1:XLEN]) : acc_q[2*XLEN-1:XLEN];

    always_comb begin
        fix_result = '0;
        unique case (f3_q)
            OP_MUL:                        fix_result = prod_fixed[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  fix_result = prod_fixed[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:               fix_result = quo_fixed;
            OP_REM, OP_REMU:               fix_result = rem_fixed;
            default:                       fix_result = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q    <= '0;
            f3_q     <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            if (accept) begin
                cnt_q    <= '0;
                f3_q     <= bus.funct3_i;
                sign_a_q <= rs1_is_signed(bus.funct3_i) & bus.rs1_i[XLEN-1];
                sign_b_q <= rs2_is_signed(bus.funct3_i) & bus.rs2_i[XLEN-1];
                if (bus.funct3_i[2]) begin
                    opnd_q <= abs_b;
                    acc_q  <= {{XLEN{1'b0}}, abs_a};
                end else begin
                    opnd_q <= abs_a;
                    acc_q  <= {{XLEN{1'b0}}, abs_b};
                end
            end else if (state_q == ST_CALC) begin
                cnt_q <= cnt_q + 6'd1;
                acc_q <= acc_step;
            end else if (state_q == ST_FIX) begin
                result_q <= fix_result;
            end
        end
    end

    assign bus.busy_o   = (state_q != ST_IDLE);
    assign bus.done_o   = (state_q == ST_DONE);
    assign bus.result_o = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    logic chk_en = 1'b0;

    int n_vec = 0;
    int n_bad = 0;

    muldiv_if #(.XLEN(32)) bus ();

    muldiv_unit #(.XLEN(32)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural RV32M result from plain 64-bit arithmetic.
    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] b);
        longint     sa, sb, ua, ub;
        logic [63:0] p;
        sa = $signed(a);
        sb = $signed(b);
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        case (f3)
            OP_MUL:    begin p = sa * sb; return p[31:0];  end
            OP_MULH:   begin p = sa * sb; return p[63:32]; end
            OP_MULHSU: begin p = sa * ub; return p[63:32]; end
            OP_MULHU:  begin p = ua * ub; return p[63:32]; end
            OP_DIV: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = sa / sb;
                return p[31:0];
            end
            OP_DIVU: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                p = ua / ub;
                return p[31:0];
            end
            OP_REM: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                p = sa % sb;
                return p[31:0];
            end
            default: begin
                if (b == 32'd0) return a;
                p = ua % ub;
                return p[31:0];
            end
        endcase
    endfunction

    // Model: an accepted request completes 34 edges later; done is seen
    // after the 33rd edge following the accepting one.
    logic        m_busy = 1'b0;
    int          m_cnt = 0;
    logic [31:0] m_result = '0;
    logic [31:0] m_pending = '0;

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            m_busy    <= 1'b0;
            m_cnt     <= 0;
            m_result  <= '0;
            m_pending <= '0;
        end else if (!m_busy) begin
            if (bus.start_i) begin
                m_busy    <= 1'b1;
                m_cnt     <= 0;
                m_pending <= ref_result(bus.funct3_i, bus.rs1_i, bus.rs2_i);
            end
        end else begin
            m_cnt <= m_cnt + 1;
            if (m_cnt == 32) m_result <= m_pending;
            if (m_cnt == 33) m_busy <= 1'b0;
        end
    end

    always @(negedge clk_i) begin
        if (chk_en) begin
            chk("busy", {31'd0, bus.busy_o}, {31'd0, m_busy});
            chk("done", {31'd0, bus.done_o}, {31'd0, (m_busy && m_cnt == 33)});
            chk("result", bus.result_o, m_result);
        end
    end

    task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        int  lat;
        logic seen;
        chk({name, "_model"}, ref_result(f3, a, b), exp);
        bus.funct3_i = f3;
        bus.rs1_i    = a;
        bus.rs2_i    = b;
        bus.start_i  = 1'b1;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 60) begin
            @(negedge clk_i);
            lat++;
            if (lat == 1) begin
                bus.start_i = 1'b0;
                bus.rs1_i   = ~a;
                bus.rs2_i   = a ^ b;
            end
            if (bus.done_o) begin
                seen = 1'b1;
                chk({name, "_result"}, bus.result_o, exp);
                chk({name, "_latency"}, 32'(lat), 32'd34);
            end
        end
        if (!seen) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s_timeout: got no done expected done within 60 cycles", name);
        end
        @(negedge clk_i);
    endtask

    initial begin
        int dcount;
        bus.start_i  = 1'b0;
        bus.funct3_i = 3'b000;
        bus.rs1_i    = '0;
        bus.rs2_i    = '0;
        #1 rst_i = 1'b1;
        chk_en = 1'b1;
        @(negedge clk_i);
        chk("rst_busy", {31'd0, bus.busy_o}, 32'd0);
        chk("rst_done", {31'd0, bus.done_o}, 32'd0);
        chk("rst_result", bus.result_o, 32'd0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);

        run_op("mul_neg",    OP_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB);
        run_op("mulh_min",   OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        run_op("mulhu_max",  OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("mulhsu",     OP_MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF);
        run_op("div_neg",    OP_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD);
        run_op("rem_neg",    OP_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF);
        run_op("divu",       OP_DIVU,   32'd100,       32'd7,         32'd14);
        run_op("remu",       OP_REMU,   32'd100,       32'd7,         32'd2);
        run_op("divu_zero",  OP_DIVU,   32'h1234,      32'd0,         32'hFFFF_FFFF);
        run_op("rem_zero",   OP_REM,    32'h1234,      32'd0,         32'h1234);
        run_op("div_ovf",    OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_op("rem_ovf",    OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        run_op("div_negz",   OP_DIV,    32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF);
        run_op("rem_negz",   OP_REM,    32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9);
        run_op("mul_hi_big", OP_MULH,   32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000);

        // Start while busy must be ignored; operands may change mid-run.
        bus.funct3_i = OP_MUL;
        bus.rs1_i    = 32'd3;
        bus.rs2_i    = 32'd5;
        bus.start_i  = 1'b1;
        dcount = 0;
        for (int i = 1; i <= 80; i++) begin
            @(negedge clk_i);
            if (i == 1) bus.start_i = 1'b0;
            if (i == 10) begin
                bus.funct3_i = OP_DIV;
                bus.rs1_i    = 32'd9;
                bus.rs2_i    = 32'd9;
                bus.start_i  = 1'b1;
            end
            if (i == 11) begin
                bus.start_i = 1'b0;
                bus.rs1_i   = 32'd100;
            end
            if (bus.done_o) begin
                dcount++;
                if (dcount == 1) begin
                    chk("busy_ign_result", bus.result_o, 32'd15);
                    chk("busy_ign_latency", 32'(i), 32'd34);
                end
            end
        end
        chk("busy_ign_done_count", 32'(dcount), 32'd1);

        // Asynchronous reset in the middle of a divide.
        bus.funct3_i = OP_DIV;
        bus.rs1_i    = 32'd1000;
        bus.rs2_i    = 32'd3;
        bus.start_i  = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk_i);
            if (i == 1) bus.start_i = 1'b0;
        end
        #2 rst_i = 1'b1;
        #1;
        chk("arst_busy", {31'd0, bus.busy_o}, 32'd0);
        chk("arst_done", {31'd0, bus.done_o}, 32'd0);
        chk("arst_result", bus.result_o, 32'd0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        dcount = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk_i);
            if (bus.done_o) dcount++;
        end
        chk("arst_no_done", 32'(dcount), 32'd0);
        run_op("mul_after_rst", OP_MUL, 32'd6, 32'd7, 32'd42);

        repeat (3) @(negedge clk_i);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit for the core's execute stage. Takes the two source operands read from the register file plus `funct3`, and runs a fixed-latency shift-add multiply or restoring divide. It returns a 32-bit result that the writeback path drives onto the register file's destination write data. The unit stalls the pipeline via `busy_o` and signals completion with a one-cycle `done_o` pulse.

## Interface
- `XLEN`, default 32: operand/result width; only 32 is supported.
- `clk_i` input 1: clock; all state changes on its rising edge.
- `rst_i` input 1: reset, asynchronous, active-high.
- `start_i` input 1: request; sampled only in IDLE.
- `funct3_i` input 3: operation. 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `rs1_i` input 32: operand A (dividend / multiplicand).
- `rs2_i` input 32: operand B (divisor / multiplier).
- `busy_o` output 1: high in every state except IDLE.
- `done_o` output 1: one-cycle pulse; `result_o` is valid in that cycle.
- `result_o` output 32: result; holds its value until the next accepted start.

## Operation
- FSM states:
  - IDLE: `start_i`=1 latches `rs1_i`, `rs2_i` and `funct3_i`, clears the 6-bit iteration counter, and moves to CALC.
  - CALC: exactly 32 iterations, then FIX.
  - FIX: one cycle, then DONE.
  - DONE: one cycle, then IDLE.
- Signed operands are converted to magnitudes at latch time:
  - MULH: both operands signed.
  - MULHSU: `rs1` signed, `rs2` unsigned.
  - DIV and REM: both operands signed.
  - All other operations: both operands unsigned.
- Multiply: unsigned 32x32 shift-add into a 64-bit accumulator, one multiplier bit per iteration, LSB first.
  - FIX negates the 64-bit product if the operand signs differ.
  - MUL returns bits [31:0]; MULH, MULHSU and MULHU return bits [63:32].
- Divide: restoring division, one quotient bit per iteration, MSB first, with a 33-bit partial remainder.
  - FIX negates the quotient if sign(A) xor sign(B).
  - FIX negates the remainder if sign(A) is set.
- Divide by zero (B=0):
  - DIV and DIVU return 0xFFFFFFFF.
  - REM and REMU return A unchanged.
  - The full latency still applies.
- Signed overflow (DIV with A=0x80000000, B=0xFFFFFFFF): quotient 0x80000000, REM 0. The full latency still applies.
- `start_i` while busy is ignored. It is not queued and has no effect on the running operation.
- Operand inputs may change freely after the start edge; only the latched copies are used.
- Reset at any time, including mid-operation:
  - state IDLE, counter 0, all datapath registers 0;
  - `busy_o`=0, `done_o`=0, `result_o`=0;
  - no `done_o` pulse is emitted for the aborted operation.

## Timing
- Reset values: `busy_o`=0, `done_o`=0, `result_o`=0x00000000.
- All outputs are registered or decoded from state only. There is no combinational path from inputs to outputs.
- Latency is fixed at 34 cycles for every op and every operand value:
  - E0: start is sampled in IDLE.
  - E1 through E32: CALC iterations.
  - E33: FIX.
  - `done_o`=1 for exactly one cycle, between E33 and E34.
- `busy_o` rises after E0 and stays high through the DONE cycle. It falls after E34.
- Back-to-back operation: a start asserted in the cycle after `done_o` is accepted at E34+1. Minimum issue interval is 35 cycles.
- Counter arithmetic: 6-bit counter; CALC exits when the counter reaches 31 and is incremented. There is no wrap-around within an operation.

## Structure
- Shared package `muldiv_pkg`:
  - `funct3` op encodings (localparams `OP_MUL` … `OP_REMU`);
  - FSM state encoding (IDLE, CALC, FIX, DONE, 2 bits);
  - `ITERATIONS`=32.
- Single module; no sub-module is warranted. Multiply and divide share the 64-bit accumulator/remainder register and the 32-bit operand register.
- Negate/absolute-value logic is a package function reused at latch time and in FIX.

## Test plan
- MUL A=7, B=0xFFFFFFFD (−3) → `result_o`=0xFFFFFFEB; `done_o` pulses exactly 34 cycles after the start edge; `busy_o` high throughout.
- MULH A=B=0x80000000 → 0x40000000. MULHU A=B=0xFFFFFFFF → 0xFFFFFFFE. MULHSU A=0xFFFFFFFF, B=2 → 0xFFFFFFFF.
- DIV A=0xFFFFFFF9 (−7), B=2 → 0xFFFFFFFD. REM with the same operands → 0xFFFFFFFF. DIVU A=100, B=7 → 14. REMU with the same operands → 2.
- DIVU A=0x1234, B=0 → 0xFFFFFFFF. REM A=0x1234, B=0 → 0x1234. DIV A=0x80000000, B=0xFFFFFFFF → 0x80000000. REM with the same operands → 0. All take the full 34-cycle latency.
- Start MUL 3×5, pulse `start_i` with different operands at cycle 10, and change `rs1_i` mid-run → result is 15; no second `done_o`.
- Start DIV, assert `rst_i` asynchronously at cycle 20 → `busy_o`, `done_o` and `result_o` go to 0 immediately with no done pulse. A new MUL 6×7 after reset release → 42 at 34 cycles.
